// File: rtl/hs_rsp_queue.sv
// Response queue: C_DEPTH slots of C_WORDS words, filled by a producer and
// drained one slot at a time by a handshake consumer (RspReq/RspAck).
module hs_rsp_queue #(
  parameter int unsigned C_DEPTH = 2,
  parameter int unsigned C_WORDS = 16,
  parameter int unsigned C_DW    = 32,
  parameter int unsigned C_IDW   = 5
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       rsp_we,
  input  logic [$clog2(C_WORDS)-1:0] rsp_waddr,
  input  logic [C_DW-1:0]            rsp_wdata,
  input  logic                       rsp_done,
  input  logic [C_IDW-1:0]           rsp_id,
  input  logic                       rsp_sts,
  output logic                       rsp_full,
  output logic                       rsp_ovf,
  output logic                       RspReq,
  input  logic                       RspAck,
  output logic [C_IDW-1:0]           RspId,
  output logic                       RspSts,
  input  logic [$clog2(C_WORDS)-1:0] RspAddr,
  output logic [C_DW-1:0]            Rsp
);

  localparam int unsigned AW = $clog2(C_WORDS);
  localparam int unsigned PW = $clog2(C_DEPTH);
  localparam int unsigned CW = $clog2(C_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  // Slot storage is deliberately not reset.
  logic [C_DW-1:0]  mem     [C_DEPTH*C_WORDS];
  logic [C_IDW-1:0] id_mem  [C_DEPTH];
  logic             sts_mem [C_DEPTH];

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, ovf_q;
  state_e           state_q, state_d;
  logic [C_IDW-1:0] id_q;
  logic             sts_q;
  logic [C_DW-1:0]  rsp_q;

  logic             wr_en, push, pop, load_head;

  // Producer side gating: the registered full flag blocks writes and commits.
  always_comb begin
    wr_en  = rsp_we && !full_q;
    push   = rsp_done && !full_q;
    pop    = (state_q == StReq) && RspAck;
    tail_d = push ? PW'(tail_q + 1'b1) : tail_q;
    head_d = pop ? PW'(head_q + 1'b1) : head_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Read handshake FSM: IDLE waits for data, REQ holds the request, GAP forces a low gap.
  always_comb begin
    state_d   = state_q;
    RspReq    = 1'b0;
    load_head = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d   = StReq;
          load_head = 1'b1;
        end
      end
      StReq: begin
        RspReq = 1'b1;
        if (RspAck) state_d = StGap;
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Queue pointers, count, flags, FSM and registered head outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= StIdle;
      id_q    <= '0;
      sts_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= (count_d == CW'(C_DEPTH));
      ovf_q   <= rsp_done && full_q;
      state_q <= state_d;
      rsp_q   <= mem[{head_q, RspAddr}];
      // Head entry is latched as REQ is entered; it cannot change until the pop.
      if (load_head) begin
        id_q  <= id_mem[head_q];
        sts_q <= sts_mem[head_q];
      end
    end
  end

  // Slot data and tag storage; a write and a commit in one cycle land in the same slot.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      if (wr_en) mem[{tail_q, rsp_waddr}] <= rsp_wdata;
      if (push) begin
        id_mem[tail_q]  <= rsp_id;
        sts_mem[tail_q] <= rsp_sts;
      end
    end
  end

  assign rsp_full = full_q;
  assign rsp_ovf  = ovf_q;
  assign RspId    = id_q;
  assign RspSts   = sts_q;
  assign Rsp      = rsp_q;

endmodule

// File: doc/hs_rsp_queue.md
HS_RSP_QUEUE -- requirements
Module: hs_rsp_queue

Interface
REQ-001 Parameter C_DEPTH, default 2: number of response slots; power of two, 2..8.
REQ-002 Parameter C_WORDS, default 16: words per slot; power of two, 4..32.
REQ-003 Parameter C_DW, default 32: response word width.
REQ-004 Parameter C_IDW, default 5: response tag width.
REQ-005 sys_clk  in  1: the single clock; all logic SHALL be rising-edge sys_clk.
REQ-006 sys_rst  in  1: synchronous, active-high reset.
REQ-007 rsp_we  in  1: write strobe into the current fill slot.
REQ-008 rsp_waddr  in  log2(C_WORDS): word index in the fill slot.
REQ-009 rsp_wdata  in  C_DW: write data.
REQ-010 rsp_done  in  1: commit strobe for the fill slot (single-cycle).
REQ-011 rsp_id  in  C_IDW: tag captured at commit.
REQ-012 rsp_sts  in  1: status bit captured at commit.
REQ-013 rsp_full  out  1: all C_DEPTH slots committed and not yet consumed.
REQ-014 rsp_ovf  out  1: one-cycle pulse when a commit is dropped.
REQ-015 RspReq  out  1: head response available to the consumer.
REQ-016 RspAck  in  1: consumer has finished with the head response.
REQ-017 RspId  out  C_IDW: tag of the head response.
REQ-018 RspSts  out  1: status of the head response.
REQ-019 RspAddr  in  log2(C_WORDS): word index into the head slot.
REQ-020 Rsp  out  C_DW: head-slot word at RspAddr.

Function
REQ-021 Storage SHALL be C_DEPTH x C_WORDS words plus one {id, sts} entry per slot, managed as a circular queue with a tail (fill) pointer, a head (read) pointer, and a count 0..C_DEPTH.
REQ-022 rsp_we with rsp_full=0 SHALL write rsp_wdata to slot[tail][rsp_waddr] at the clock edge; rsp_we with rsp_full=1 SHALL be ignored and SHALL NOT change storage.
REQ-023 rsp_done with rsp_full=0 SHALL store {rsp_id, rsp_sts} for slot[tail], advance tail modulo C_DEPTH, and increment count.
REQ-024 A write and a commit in the same cycle SHALL write the data word into the slot being committed.
REQ-025 rsp_done with rsp_full=1 SHALL be dropped, and rsp_ovf SHALL be 1 for exactly the following cycle; pointers and count SHALL be unchanged.
REQ-026 rsp_full SHALL be a registered flag equal to (count == C_DEPTH).
REQ-027 The read FSM SHALL have three states: IDLE, REQ and GAP.
REQ-028 In IDLE, when count > 0, the FSM SHALL go to REQ.
REQ-029 In REQ, RspReq SHALL be 1; when RspAck=1, the FSM SHALL advance head modulo C_DEPTH, decrement count, and go to GAP.
REQ-030 GAP SHALL last one cycle with RspReq=0 and SHALL then go to IDLE, so RspReq is low for at least 2 cycles between consecutive responses.
REQ-031 RspAck outside REQ SHALL be ignored.
REQ-032 A commit and a pop in the same cycle SHALL leave count unchanged and move both pointers.
REQ-033 A commit while full and a pop in the same cycle SHALL still be dropped (rsp_full is the registered value) and SHALL pulse rsp_ovf.
REQ-034 RspId and RspSts SHALL be registered copies of the head slot's entry, valid whenever RspReq=1.
REQ-035 Rsp SHALL be registered: Rsp in cycle n+1 equals slot[head][RspAddr] sampled in cycle n (read latency 1).
REQ-036 Address arithmetic SHALL be unsigned, with pointers wrapping C_DEPTH-1 -> 0.
REQ-037 rsp_waddr and RspAddr SHALL be exactly log2(C_WORDS) bits, so no out-of-range index is possible.

Reset
REQ-038 While sys_rst=1 at a clock edge, the block SHALL set head=tail=count=0 and FSM=IDLE.
REQ-039 While sys_rst=1, outputs SHALL be RspReq=0, RspId=0, RspSts=0, Rsp=0, rsp_full=0 and rsp_ovf=0.
REQ-040 Slot storage SHALL NOT be reset; data and commits in flight at reset SHALL be discarded.

Verification
REQ-041 Write words 0..15 = 0xA0000000+i, commit with id=5, sts=1 -> RspReq rises within 2 cycles with RspId=5, RspSts=1; RspAddr=i returns 0xA0000000+i one cycle later.
REQ-042 With C_DEPTH=2, commit 3 responses with no ack -> rsp_full=1 after the 2nd commit; 3rd commit pulses rsp_ovf for 1 cycle; the queue still holds the first 2 ids in order.
REQ-043 Ack each response -> RspReq deasserts for at least 2 cycles; the next head shows the next id; count reaches 0 and RspReq stays 0.
REQ-044 When full, commit and ack in the same cycle -> commit dropped with an rsp_ovf pulse, count = C_DEPTH-1, rsp_full=0 next cycle.
REQ-045 Hold RspReq=1 with 2 slots queued, then assert sys_rst for 1 cycle -> all outputs 0 the next cycle; RspReq stays 0 until a new commit.
